// File: rtl/sonic_echo_model_if.sv
// Trigger/echo bundle between a range controller (master) and the sensor emulator (slave).
// No backpressure: all signals are plain levels or single-cycle pulses.
interface sonic_echo_model_if;
    logic       trig;
    logic [8:0] distance;
    logic       echo;
    logic       busy;
    logic       short_trig;

    modport master (
        output trig,
        output distance,
        input  echo,
        input  busy,
        input  short_trig
    );

    modport slave (
        input  trig,
        input  distance,
        output echo,
        output busy,
        output short_trig
    );
endinterface

// File: rtl/sonic_echo_model.sv
// Ultrasonic sensor emulator: qualifies trig (2-cycle sync), echo rises BURST+1 cycles after trig_s falls.
// No backpressure; trig is ignored while busy. SONIC_ECHO_JITTER_EN adds 0-15 us LFSR jitter to in-range echoes.
module sonic_echo_model #(
    parameter int unsigned CLK_PER_US  = 100,
    parameter int unsigned MIN_TRIG_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLDOFF_US  = 10
) (
    input  logic              clk,
    input  logic              rst,
    sonic_echo_model_if.slave bus
);
    localparam logic [21:0] MIN_CYC     = 22'(MIN_TRIG_US * CLK_PER_US);
    localparam logic [21:0] BURST_CYC   = 22'(BURST_US * CLK_PER_US);
    localparam logic [21:0] CM_CYC      = 22'(US_PER_CM * CLK_PER_US);
    localparam logic [21:0] TIMEOUT_CYC = 22'(TIMEOUT_US * CLK_PER_US);
    localparam logic [21:0] HOLD_CYC    = 22'(HOLDOFF_US * CLK_PER_US);
    localparam logic [21:0] MAX_DIST    = 22'(MAX_CM);

    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

    state_t      state;
    logic        trig_m;
    logic        trig_s;
    logic        trig_d;
    logic [1:0]  sync_ok;
    logic        armed;
    logic [21:0] cnt;
    logic [21:0] w_reg;
    logic [21:0] w_next;
    logic [21:0] dist_ext;
    logic        in_range;
    logic        rise;
    logic        echo_q;
    logic        busy_q;
    logic        short_q;
`ifdef SONIC_ECHO_JITTER_EN
    logic [7:0]  lfsr;
`endif

    assign dist_ext = {13'd0, bus.distance};
    assign in_range = (bus.distance != 9'd0) && (dist_ext <= MAX_DIST);
    // A level already high when reset releases must drop low once before edges count.
    assign rise     = armed && trig_s && !trig_d;

    always_comb begin
        w_next = TIMEOUT_CYC;
        if (in_range) begin
`ifdef SONIC_ECHO_JITTER_EN
            w_next = dist_ext * CM_CYC + {18'd0, lfsr[3:0]} * 22'(CLK_PER_US);
`else
            w_next = dist_ext * CM_CYC;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            trig_m  <= 1'b0;
            trig_s  <= 1'b0;
            trig_d  <= 1'b0;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
            cnt     <= 22'd0;
            w_reg   <= 22'd0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
`ifdef SONIC_ECHO_JITTER_EN
            lfsr    <= 8'h5A;
`endif
        end else begin
            trig_m  <= bus.trig;
            trig_s  <= trig_m;
            trig_d  <= trig_s;
            sync_ok <= {sync_ok[0], 1'b1};
            armed   <= armed | (sync_ok[1] & ~trig_s);
            short_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= TRIG_HI;
                        cnt   <= 22'd1;   // the edge cycle itself counts as high time
                    end
                end
                TRIG_HI: begin
                    if (trig_s) begin
                        if (cnt != '1) cnt <= cnt + 22'd1;
                    end else if (cnt >= MIN_CYC) begin
                        w_reg  <= w_next;
                        busy_q <= 1'b1;
                        cnt    <= BURST_CYC - 22'd1;
                        state  <= BURST;
`ifdef SONIC_ECHO_JITTER_EN
                        lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
                    end else begin
                        short_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                BURST: begin
                    if (cnt == 22'd0) begin
                        echo_q <= 1'b1;
                        cnt    <= w_reg - 22'd1;
                        state  <= ECHO;
                    end else begin
                        cnt <= cnt - 22'd1;
                    end
                end
                ECHO: begin
                    if (cnt == 22'd0) begin
                        echo_q <= 1'b0;
                        cnt    <= HOLD_CYC - 22'd1;
                        state  <= HOLDOFF;
                    end else begin
                        cnt <= cnt - 22'd1;
                    end
                end
                HOLDOFF: begin
                    if (cnt == 22'd0) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 22'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.echo       = echo_q;
    assign bus.busy       = busy_q;
    assign bus.short_trig = short_q;
endmodule

// File: tb/tb_sonic_echo_model.sv
// Bench for sonic_echo_model with scaled-down timing parameters; scoreboard plus edge-driven monitor.
module tb_sonic_echo_model;
    localparam int CPU       = 2;
    localparam int MIN_US    = 5;
    localparam int BURST_US  = 10;
    localparam int CM_US     = 3;
    localparam int MAXCM     = 400;
    localparam int TMO_US    = 1500;
    localparam int HOLD_US   = 4;
    localparam int MIN_CYC   = MIN_US * CPU;
    localparam int BURST_CYC = BURST_US * CPU;
    localparam int HOLD_CYC  = HOLD_US * CPU;

    typedef struct {
        int busy_rise;
        int echo_rise;
        int w_lo;
        int w_hi;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    int   done = 0;
    int   stray = 0;
    int   model_free_at = 0;
    int   last_echo_rise = 0;
    bit   mon_en = 0;
    exp_t sb[$];
    int   short_q[$];
    int   wlog[$];
    int   first_run[$];

    sonic_echo_model_if dut_if();

    sonic_echo_model #(
        .CLK_PER_US(CPU), .MIN_TRIG_US(MIN_US), .BURST_US(BURST_US), .US_PER_CM(CM_US),
        .MAX_CM(MAXCM), .TIMEOUT_US(TMO_US), .HOLDOFF_US(HOLD_US)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dut_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Reference: echo width straight from the ranging rules.
    task automatic model_width(input int d, output int lo, output int hi);
        if (d >= 1 && d <= MAXCM) begin
            lo = d * CM_US * CPU;
`ifdef SONIC_ECHO_JITTER_EN
            hi = lo + 15 * CPU;
`else
            hi = lo;
`endif
        end else begin
            lo = TMO_US * CPU;
            hi = lo;
        end
    endtask

    task automatic send(input int hi, input logic [8:0] d);
        int   q;
        int   p;
        int   lo;
        int   whi;
        exp_t e;
        dut_if.distance = d;
        @(posedge clk); #1;
        q = cyc;
        dut_if.trig = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        dut_if.trig = 1'b0;
        p = cyc;
        if (q + 2 < model_free_at) begin
            // sensor busy: pulse is ignored entirely
        end else if (hi >= MIN_CYC) begin
            model_width(int'(d), lo, whi);
            e.busy_rise = p + 3;
            e.echo_rise = p + 3 + BURST_CYC;
            e.w_lo = lo;
            e.w_hi = whi;
            sb.push_back(e);
            last_echo_rise = e.echo_rise;
            model_free_at = e.echo_rise + whi + HOLD_CYC;
            accepted++;
        end else begin
            short_q.push_back(p + 3);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int gap);
        while (cyc < model_free_at + gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        model_free_at = cyc;
    endtask

    // Monitor: follows output edges and pops the scoreboard.
    initial begin
        bit   busy_p = 0;
        bit   echo_p = 0;
        bit   have_cur = 0;
        int   echo_start = 0;
        int   echo_fall = 0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (dut_if.short_trig) begin
                    if (short_q.size() == 0) chk("unexpected_short_trig", cyc, -1);
                    else chk("short_trig_cycle", cyc, short_q.pop_front());
                end
                if (dut_if.echo && !dut_if.busy) stray++;
                if (dut_if.busy && !busy_p) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_busy", cyc, -1);
                        have_cur = 0;
                    end else begin
                        cur = sb.pop_front();
                        have_cur = 1;
                        chk("busy_rise", cyc, cur.busy_rise);
                    end
                end
                if (dut_if.echo && !echo_p) begin
                    echo_start = cyc;
                    if (have_cur) chk("echo_rise", cyc, cur.echo_rise);
                    else chk("unexpected_echo", cyc, -1);
                end
                if (!dut_if.echo && echo_p) begin
                    echo_fall = cyc;
                    wlog.push_back(cyc - echo_start);
                    if (have_cur) chk_range("echo_width", cyc - echo_start, cur.w_lo, cur.w_hi);
                end
                if (!dut_if.busy && busy_p) begin
                    chk("busy_fall", cyc, echo_fall + HOLD_CYC);
                    done++;
                    have_cur = 0;
                end
            end
            busy_p = dut_if.busy;
            echo_p = dut_if.echo;
        end
    end

    initial begin
        while (cyc < 90000) @(posedge clk);
        $display("FAIL watchdog actual=%0d cycles required=<90000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  hi;
        bit  seen;
        rst = 1'b1;
        dut_if.trig = 1'b0;
        dut_if.distance = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_echo", int'(dut_if.echo), 0);
        chk("reset_busy", int'(dut_if.busy), 0);
        chk("reset_short_trig", int'(dut_if.short_trig), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Reset mid-echo, with trig held high across the release.
        send(20, 9'd10);
        for (int i = 0; i < 200 && !dut_if.echo; i++) @(posedge clk);
        chk("echo_before_reset", int'(dut_if.echo), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_echo", int'(dut_if.echo), 0);
        chk("async_reset_busy", int'(dut_if.busy), 0);
        chk("async_reset_short_trig", int'(dut_if.short_trig), 0);
        dut_if.trig = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= dut_if.busy | dut_if.echo;
        end
        dut_if.trig = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            seen |= dut_if.busy | dut_if.echo | dut_if.short_trig;
        end
        chk("no_echo_without_fresh_edge", int'(seen), 0);
        sb.delete();
        short_q.delete();
        accepted = 0;
        model_free_at = cyc;
        mon_en = 1;

        // Directed cases.
        send(20, 9'd10);
        wait_idle(3);
        send(MIN_CYC, 9'd25);
        wait_idle(3);
        send(MIN_CYC - 1, 9'd25);
        wait_idle(3);
        send(5, 9'd100);
        wait_idle(3);
        send(20, 9'd0);
        wait_idle(3);
        send(20, 9'd401);
        wait_idle(3);
        send(20, 9'd400);
        wait_idle(3);
        send(20, 9'd1);
        wait_idle(3);

        // Retrigger during echo plus a distance change; next trig uses the new distance.
        send(20, 9'd50);
        while (cyc < last_echo_rise + 20) begin
            @(posedge clk); #1;
        end
        send(15, 9'd300);
        wait_idle(4);
        send(20, 9'd300);
        wait_idle(3);

        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 3))
                0:       hi = $urandom_range(1, MIN_CYC - 1);
                1:       hi = MIN_CYC;
                2:       hi = MIN_CYC - 1;
                default: hi = $urandom_range(MIN_CYC, MIN_CYC + 60);
            endcase
            send(hi, 9'($urandom_range(0, 511)));
            wait_idle($urandom_range(1, 6));
        end

        // Identical reset sequences must give identical widths.
        for (int run = 0; run < 2; run++) begin
            wait_idle(5);
            pulse_reset();
            wlog.delete();
            for (int k = 0; k < 3; k++) begin
                send(20, 9'd10);
                wait_idle(3);
            end
            wait_idle(5);
            if (run == 0) first_run = wlog;
        end
        chk("repeat_width_count", wlog.size(), 3);
        for (int k = 0; k < 3 && k < wlog.size() && k < first_run.size(); k++)
            chk("repeat_width", wlog[k], first_run[k]);

        wait_idle(10);
        chk("scoreboard_drained", sb.size(), 0);
        chk("short_queue_drained", short_q.size(), 0);
        chk("completed_measurements", done, accepted);
        chk("echo_outside_busy", stray, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
